layer_address_sequencer: RTL and testbench
==========================================

# layer_address_sequencer

Parametrised, self-iterating address sequencer for the CNN accelerator's neuron buffers. It accepts one command per handshake and walks the nested row/column (and pooling-window) loops in hardware, emitting one read/write address pair per cycle under valid/ready flow control. It sits between the instruction decoder and the neuron buffer banks. It replaces per-instruction INCR/JUMP stepping of read/write address registers with autonomous loop counters, bank rotation and a completion pulse.

## Interface
- `AB`, 11: buffer address width.
- `AL`, 7: loop-count / step register width.
- `NB_DEPTH`, 2: log2 of neuron bank count; banks = `1<<NB_DEPTH`.
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `insValid` in 1: command present.
- `insReady` out 1: sequencer can accept a command.
- `insOpcode` in 2: 00 CFG, 01 RUN_CONV, 10 RUN_POOL, 11 NOP.
- `insSel` in 3: CFG target register select.
- `insData` in AL: CFG value.
- `addrValid` out 1: address pair valid.
- `addrReady` in 1: downstream accepts the address pair.
- `nReadAddress` out AB: neuron read address.
- `nWriteAddress` out AB: neuron write address.
- `bankSel` out NB_DEPTH: active neuron bank.
- `writeEn` out 1: write qualifier for the current pair.
- `busy` out 1: a RUN is in progress.
- `done` out 1: one-cycle pulse at RUN completion.

## Operation
- Config registers, written by CFG via `insSel`:
  - 0 `rows`
  - 1 `cols`
  - 2 `neuronStep` (read row pitch)
  - 3 `pooledStep` (write row pitch)
  - 4 `P` (pool factor)
  - Other values of `insSel` are ignored.
- CFG completes in one cycle. It never raises `busy` or `done`.
- States:
  - IDLE: `insReady`=1. A handshake with RUN_CONV goes to CONV; RUN_POOL goes to POOL; CFG or NOP stays in IDLE.
  - CONV: iterate r∈[0,rows), c∈[0,cols).
    - `nReadAddress` = r·neuronStep + c.
    - `nWriteAddress` = r·pooledStep + c.
    - `writeEn`=1 on every pair.
  - POOL: iterate output r∈[0,rows), c∈[0,cols), window pr,pc∈[0,P), with pc innermost.
    - `nReadAddress` = (r·P+pr)·neuronStep + c·P + pc.
    - `nWriteAddress` = r·pooledStep + c.
    - `writeEn`=1 only on the pair where pr=pc=P−1.
  - DONE: a single cycle with `done`=1, then return to IDLE.
- Addresses are formed by running accumulators (adds only, no multipliers). All address arithmetic is truncated modulo 2^AB; wrap-around is silent.
- `bankSel` increments after the last pair of each output row and wraps modulo `1<<NB_DEPTH`. It is reset to 0 at each RUN start.
- Degenerate configurations:
  - `rows`=0 or `cols`=0: no pairs are emitted; the FSM goes straight to DONE.
  - `P`=0 in POOL is treated as `P`=1.
- Reset values:
  - `insReady`=1.
  - `addrValid`, `writeEn`, `busy`, `done`, `bankSel`, both addresses = 0.
  - Config: `rows`=`cols`=`neuronStep`=`pooledStep`=0, `P`=1.
- Reset asserted mid-RUN aborts immediately to the reset values. No pair is emitted after `RST_N` falls.

## Timing
- A command is accepted on a rising edge with `insValid`&&`insReady`.
- `insReady`=0 throughout CONV/POOL/DONE. Commands presented then are held off, not dropped.
- The first `addrValid` is asserted in the cycle after a RUN is accepted.
- Throughput is one pair per cycle while `addrReady`=1.
- While `addrValid`&&!`addrReady`, all of `nReadAddress`, `nWriteAddress`, `bankSel` and `writeEn` stay stable and the counters hold.
- `addrValid` drops in the cycle after the last pair's handshake. `done`=1 in that same cycle.
- `insReady` rises the cycle after `done`.
- `busy` is high from the cycle after acceptance until the `done` cycle inclusive.
- Degenerate RUN: `done` appears the cycle after acceptance.

## Configuration
- `SEQ_POOL_EN`:
  - Defined: POOL state, the window counters and the `P` register are built.
  - Undefined: none of these exist. RUN_POOL behaves as a degenerate RUN (no pairs, `done` next cycle), and CFG to `insSel`=4 is ignored.

## Test plan
- Reset, then CFG rows=2, cols=3, neuronStep=8, pooledStep=4, then RUN_CONV with `addrReady`=1 → read addresses 0,1,2,8,9,10; write addresses 0,1,2,4,5,6; `bankSel` 0,0,0,1,1,1; `done` one cycle after the 6th handshake.
- CFG rows=1, cols=2, P=2, neuronStep=8, then RUN_POOL → read addresses 0,1,8,9,2,3,10,11; `writeEn` high only on pairs 4 and 8, with write addresses 0 and 1.
- RUN_CONV with `addrReady` toggled 1,0,0,1 → the address pair is held across the stall cycles and no address is skipped or duplicated.
- CFG cols=0, then RUN_CONV → `addrValid` never rises; `done`=1 in the cycle after acceptance; `insReady` returns high.
- Drop `RST_N` during the 3rd pair of a RUN → all outputs go to reset values asynchronously; `insReady`=1 after release.
- NB_DEPTH=1, rows=3 → `bankSel` sequence per row is 0,1,0, showing wrap-around.

Source files
------------

// File: rtl/layer_address_sequencer_if.sv
// Command and address-pair bus of layer_address_sequencer.
// slave = sequencer side, master = instruction decoder / neuron buffer side.
interface layer_address_sequencer_if #(
  parameter int AB       = 11,
  parameter int AL       = 7,
  parameter int NB_DEPTH = 2
);
  logic                insValid;
  logic                insReady;
  logic [1:0]          insOpcode;
  logic [2:0]          insSel;
  logic [AL-1:0]       insData;
  logic                addrValid;
  logic                addrReady;
  logic [AB-1:0]       nReadAddress;
  logic [AB-1:0]       nWriteAddress;
  logic [NB_DEPTH-1:0] bankSel;
  logic                writeEn;
  logic                busy;
  logic                done;

  modport slave (
    input  insValid, insOpcode, insSel, insData, addrReady,
    output insReady, addrValid, nReadAddress, nWriteAddress, bankSel, writeEn, busy, done
  );

  modport master (
    output insValid, insOpcode, insSel, insData, addrReady,
    input  insReady, addrValid, nReadAddress, nWriteAddress, bankSel, writeEn, busy, done
  );
endinterface

// File: rtl/layer_address_sequencer.sv
// Self-iterating neuron-buffer address sequencer: CFG registers, CONV/POOL loop walk, bank rotation.
// Optional pooling support is built when SEQ_POOL_EN is defined.
module layer_address_sequencer #(
  parameter int AB       = 11,
  parameter int AL       = 7,
  parameter int NB_DEPTH = 2
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  layer_address_sequencer_if.slave          bus
);

  localparam logic [1:0] OP_CFG  = 2'b00;
  localparam logic [1:0] OP_CONV = 2'b01;
  localparam logic [1:0] OP_POOL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
`ifdef SEQ_POOL_EN
    S_POOL = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [AL-1:0]       r_rows;
  logic [AL-1:0]       r_cols;
  logic [AL-1:0]       r_nstep;
  logic [AL-1:0]       r_pstep;
  logic [AL-1:0]       r_r;
  logic [AL-1:0]       r_c;
  logic [AB-1:0]       r_rd_row;
  logic [AB-1:0]       r_wr_row;
  logic                r_ins_ready;
  logic                r_addr_valid;
  logic [AB-1:0]       r_rd;
  logic [AB-1:0]       r_wr;
  logic [NB_DEPTH-1:0] r_bank;
  logic                r_we;
  logic                r_busy;
  logic                r_done;

  logic                w_last_c;
  logic                w_last_r;
  logic                w_finish;
  logic                w_degen;
  logic                w_first_we;
  logic [AL-1:0]       w_nxt_c;
  logic [AL-1:0]       w_nxt_r;
  logic [AB-1:0]       w_nxt_rd;
  logic [AB-1:0]       w_nxt_wr;
  logic [AB-1:0]       w_nxt_rd_row;
  logic [AB-1:0]       w_nxt_wr_row;
  logic [NB_DEPTH-1:0] w_nxt_bank;
  logic                w_nxt_we;

`ifdef SEQ_POOL_EN
  logic [AL-1:0]       r_p;
  logic [AL-1:0]       r_pr;
  logic [AL-1:0]       r_pc;
  logic [AB-1:0]       r_rd_line;
  logic [AB-1:0]       r_col_off;
  logic [AL-1:0]       w_p_eff;
  logic                w_last_pr;
  logic                w_last_pc;
  logic [AL-1:0]       w_nxt_pr;
  logic [AL-1:0]       w_nxt_pc;
  logic [AB-1:0]       w_nxt_line;
  logic [AB-1:0]       w_nxt_col_off;
`endif

  // Next-pair step: CONV is walked as POOL with a 1x1 window; adds only
  always_comb begin
    w_last_c     = (r_c == r_cols - AL'(1));
    w_last_r     = (r_r == r_rows - AL'(1));
    w_nxt_c      = r_c;
    w_nxt_r      = r_r;
    w_nxt_rd     = r_rd;
    w_nxt_wr     = r_wr;
    w_nxt_rd_row = r_rd_row;
    w_nxt_wr_row = r_wr_row;
    w_nxt_bank   = r_bank;
    w_finish     = 1'b0;
    w_degen      = (r_rows == AL'(0)) || (r_cols == AL'(0));
`ifdef SEQ_POOL_EN
    w_p_eff       = ((r_state == S_POOL) && (r_p != AL'(0))) ? r_p : AL'(1);
    w_last_pc     = (r_pc == w_p_eff - AL'(1));
    w_last_pr     = (r_pr == w_p_eff - AL'(1));
    w_nxt_pc      = r_pc;
    w_nxt_pr      = r_pr;
    w_nxt_line    = r_rd_line;
    w_nxt_col_off = r_col_off;
    w_first_we    = (bus.insOpcode == OP_CONV) || (r_p <= AL'(1));
    if (!w_last_pc) begin
      w_nxt_pc = r_pc + AL'(1);
      w_nxt_rd = r_rd + AB'(1);
    end else if (!w_last_pr) begin
      w_nxt_pc   = AL'(0);
      w_nxt_pr   = r_pr + AL'(1);
      w_nxt_line = r_rd_line + AB'(r_nstep);
      w_nxt_rd   = r_rd_line + AB'(r_nstep) + r_col_off;
    end else if (!w_last_c) begin
      w_nxt_pc      = AL'(0);
      w_nxt_pr      = AL'(0);
      w_nxt_c       = r_c + AL'(1);
      w_nxt_col_off = r_col_off + AB'(w_p_eff);
      w_nxt_line    = r_rd_row;
      w_nxt_rd      = r_rd_row + r_col_off + AB'(w_p_eff);
      w_nxt_wr      = r_wr + AB'(1);
    end else if (!w_last_r) begin
      // The last window line of this row plus one pitch is the next row's first line
      w_nxt_pc      = AL'(0);
      w_nxt_pr      = AL'(0);
      w_nxt_c       = AL'(0);
      w_nxt_r       = r_r + AL'(1);
      w_nxt_col_off = AB'(0);
      w_nxt_line    = r_rd_line + AB'(r_nstep);
      w_nxt_rd_row  = r_rd_line + AB'(r_nstep);
      w_nxt_rd      = r_rd_line + AB'(r_nstep);
      w_nxt_wr_row  = r_wr_row + AB'(r_pstep);
      w_nxt_wr      = r_wr_row + AB'(r_pstep);
      w_nxt_bank    = r_bank + NB_DEPTH'(1);
    end else begin
      w_finish   = 1'b1;
      w_nxt_bank = r_bank + NB_DEPTH'(1);
    end
    w_nxt_we = (w_nxt_pr == w_p_eff - AL'(1)) && (w_nxt_pc == w_p_eff - AL'(1));
`else
    w_first_we = 1'b1;
    w_degen    = w_degen || (bus.insOpcode == OP_POOL);
    if (!w_last_c) begin
      w_nxt_c  = r_c + AL'(1);
      w_nxt_rd = r_rd + AB'(1);
      w_nxt_wr = r_wr + AB'(1);
    end else if (!w_last_r) begin
      w_nxt_c      = AL'(0);
      w_nxt_r      = r_r + AL'(1);
      w_nxt_rd_row = r_rd_row + AB'(r_nstep);
      w_nxt_rd     = r_rd_row + AB'(r_nstep);
      w_nxt_wr_row = r_wr_row + AB'(r_pstep);
      w_nxt_wr     = r_wr_row + AB'(r_pstep);
      w_nxt_bank   = r_bank + NB_DEPTH'(1);
    end else begin
      w_finish   = 1'b1;
      w_nxt_bank = r_bank + NB_DEPTH'(1);
    end
    w_nxt_we = 1'b1;
`endif
  end

  // Sequencer FSM with config registers, loop counters and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_rows       <= AL'(0);
      r_cols       <= AL'(0);
      r_nstep      <= AL'(0);
      r_pstep      <= AL'(0);
      r_r          <= AL'(0);
      r_c          <= AL'(0);
      r_rd_row     <= AB'(0);
      r_wr_row     <= AB'(0);
      r_ins_ready  <= 1'b1;
      r_addr_valid <= 1'b0;
      r_rd         <= AB'(0);
      r_wr         <= AB'(0);
      r_bank       <= NB_DEPTH'(0);
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SEQ_POOL_EN
      r_p          <= AL'(1);
      r_pr         <= AL'(0);
      r_pc         <= AL'(0);
      r_rd_line    <= AB'(0);
      r_col_off    <= AB'(0);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.insValid) begin
            case (bus.insOpcode)
              OP_CFG: begin
                case (bus.insSel)
                  3'd0: r_rows  <= bus.insData;
                  3'd1: r_cols  <= bus.insData;
                  3'd2: r_nstep <= bus.insData;
                  3'd3: r_pstep <= bus.insData;
`ifdef SEQ_POOL_EN
                  3'd4: r_p     <= bus.insData;
`endif
                  default: r_rows <= r_rows;
                endcase
              end
              OP_CONV, OP_POOL: begin
                r_r         <= AL'(0);
                r_c         <= AL'(0);
                r_rd_row    <= AB'(0);
                r_wr_row    <= AB'(0);
                r_rd        <= AB'(0);
                r_wr        <= AB'(0);
                r_bank      <= NB_DEPTH'(0);
                r_busy      <= 1'b1;
                r_ins_ready <= 1'b0;
`ifdef SEQ_POOL_EN
                r_pr        <= AL'(0);
                r_pc        <= AL'(0);
                r_rd_line   <= AB'(0);
                r_col_off   <= AB'(0);
`endif
                if (w_degen) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
`ifdef SEQ_POOL_EN
                  r_state <= (bus.insOpcode == OP_POOL) ? S_POOL : S_CONV;
`else
                  r_state <= S_CONV;
`endif
                  r_addr_valid <= 1'b1;
                  r_we         <= w_first_we;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
`ifdef SEQ_POOL_EN
        S_CONV, S_POOL: begin
`else
        S_CONV: begin
`endif
          if (bus.addrReady) begin
            r_c      <= w_nxt_c;
            r_r      <= w_nxt_r;
            r_rd_row <= w_nxt_rd_row;
            r_wr_row <= w_nxt_wr_row;
            r_bank   <= w_nxt_bank;
`ifdef SEQ_POOL_EN
            r_pr      <= w_nxt_pr;
            r_pc      <= w_nxt_pc;
            r_rd_line <= w_nxt_line;
            r_col_off <= w_nxt_col_off;
`endif
            if (w_finish) begin
              r_addr_valid <= 1'b0;
              r_we         <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_rd <= w_nxt_rd;
              r_wr <= w_nxt_wr;
              r_we <= w_nxt_we;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_ins_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.insReady      = r_ins_ready;
  assign bus.addrValid     = r_addr_valid;
  assign bus.nReadAddress  = r_rd;
  assign bus.nWriteAddress = r_wr;
  assign bus.bankSel       = r_bank;
  assign bus.writeEn       = r_we;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Bench for layer_address_sequencer: table of CFG+RUN vectors checked through a pair scoreboard,
// two DUTs (NB_DEPTH 2 and 1) share stimulus; plus a mid-run reset sequence.
module tb_layer_address_sequencer;
  localparam int AB = 11;
  localparam int AL = 7;
  localparam logic [1:0] OP_CFG  = 2'b00;
  localparam logic [1:0] OP_CONV = 2'b01;
  localparam logic [1:0] OP_POOL = 2'b10;
`ifdef SEQ_POOL_EN
  localparam bit POOL_ON = 1'b1;
`else
  localparam bit POOL_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0] op;
    int rows, cols, ns, ps, p;
    logic [3:0] rdy;
    int exp_pairs;
  } vec_t;

  typedef struct {
    logic [AB-1:0] rd, wr;
    logic [1:0]    b0;
    logic          b1;
    logic          we;
  } pair_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  layer_address_sequencer_if #(.AB(AB), .AL(AL), .NB_DEPTH(2)) if0();
  layer_address_sequencer_if #(.AB(AB), .AL(AL), .NB_DEPTH(1)) if1();

  assign if1.insValid  = if0.insValid;
  assign if1.insOpcode = if0.insOpcode;
  assign if1.insSel    = if0.insSel;
  assign if1.insData   = if0.insData;
  assign if1.addrReady = if0.addrReady;

  layer_address_sequencer #(.AB(AB), .AL(AL), .NB_DEPTH(2)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0.slave));
  layer_address_sequencer #(.AB(AB), .AL(AL), .NB_DEPTH(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1.slave));

  int n_checks = 0;
  int n_fail = 0;
  pair_t sb[$];
  vec_t tbl[10];

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_model(input vec_t v);
    int pe;
    pair_t e;
    if (v.op == OP_POOL && !POOL_ON) return;
    pe = (v.op == OP_POOL && v.p > 0) ? v.p : 1;
    for (int r = 0; r < v.rows; r++)
      for (int c = 0; c < v.cols; c++)
        for (int pr = 0; pr < pe; pr++)
          for (int pc = 0; pc < pe; pc++) begin
            e.rd = AB'(((r * pe + pr) * v.ns + c * pe + pc) & 32'h7FF);
            e.wr = AB'((r * v.ps + c) & 32'h7FF);
            e.b0 = 2'(r % 4);
            e.b1 = 1'(r % 2);
            e.we = (pr == pe - 1) && (pc == pe - 1);
            sb.push_back(e);
          end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] sel, input int data);
    @(negedge CLK);
    if0.insValid  = 1'b1;
    if0.insOpcode = op;
    if0.insSel    = sel;
    if0.insData   = AL'(data);
    for (int k = 0; k < 50 && !if0.insReady; k++) @(negedge CLK);
    if (!if0.insReady) check_eq("cmd_accept_timeout", 64'(if0.insReady), 64'd1);
    @(posedge CLK);
    #1 if0.insValid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] sel, input int data);
    send_cmd(OP_CFG, sel, data);
    @(negedge CLK);
    check_eq("cfg_no_busy_done", 64'({if0.busy, if0.done, if0.insReady}), 64'(3'b001));
  endtask

  task automatic run(input vec_t v, input string nm);
    int cyc, last_hs, hs;
    bit got_done;
    pair_t e;
    push_model(v);
    send_cmd(v.op, 3'd0, 0);
    cyc = 0; last_hs = 0; hs = 0; got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) check_eq({nm, "_first_valid"}, 64'(if0.addrValid), 64'(v.exp_pairs != 0));
      if (if0.done) begin
        got_done = 1'b1;
        check_eq({nm, "_done_timing"}, 64'(cyc), 64'(last_hs + 1));
        check_eq({nm, "_pairs"}, 64'(hs), 64'(v.exp_pairs));
        check_eq({nm, "_done_state"}, 64'({if0.addrValid, if0.busy, if0.insReady, if1.done}), 64'(4'b0101));
        check_eq({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
      end else begin
        check_eq({nm, "_busy"}, 64'(if0.busy), 64'd1);
        if (if0.addrValid) begin
          if (sb.size() == 0) begin
            check_eq({nm, "_extra_pair"}, 64'(if0.addrValid), 64'd0);
          end else begin
            e = sb[0];
            check_eq({nm, "_pair0"}, 64'({if0.nReadAddress, if0.nWriteAddress, if0.bankSel, if0.writeEn}),
                     64'({e.rd, e.wr, e.b0, e.we}));
            check_eq({nm, "_pair1"}, 64'({if1.addrValid, if1.nReadAddress, if1.nWriteAddress, if1.bankSel, if1.writeEn}),
                     64'({1'b1, e.rd, e.wr, e.b1, e.we}));
            if0.addrReady = v.rdy[(cyc - 1) % 4];
            if (if0.addrReady) begin
              void'(sb.pop_front());
              hs++;
              last_hs = cyc;
            end
          end
        end else begin
          if0.addrReady = v.rdy[(cyc - 1) % 4];
        end
      end
    end
    if (!got_done) check_eq({nm, "_done_timeout"}, 64'(got_done), 64'd1);
    @(negedge CLK);
    check_eq({nm, "_after_done"}, 64'({if0.insReady, if0.busy, if0.done, if1.insReady}), 64'(4'b1001));
    if0.addrReady = 1'b1;
    sb.delete();
  endtask

  initial begin
    vec_t v;
    int nv;
    tbl[0] = '{OP_CONV,  2, 3,   8,   4, 1, 4'b1111, 6};
    tbl[1] = '{OP_POOL,  1, 2,   8,   0, 2, 4'b1111, POOL_ON ? 8 : 0};
    tbl[2] = '{OP_CONV,  2, 3,   8,   4, 1, 4'b1001, 6};
    tbl[3] = '{OP_CONV,  3, 2,   5,   3, 1, 4'b1111, 6};
    tbl[4] = '{OP_CONV,  2, 0,   8,   4, 1, 4'b1111, 0};
    tbl[5] = '{OP_CONV,  0, 3,   8,   4, 1, 4'b1111, 0};
    tbl[6] = '{OP_CONV, 20, 2, 127, 100, 1, 4'b0110, 40};
    tbl[7] = '{OP_CONV,  5, 1,   1,   1, 1, 4'b1011, 5};
    tbl[8] = '{OP_POOL,  2, 2,   3,   5, 0, 4'b1111, POOL_ON ? 4 : 0};
    tbl[9] = '{OP_POOL,  2, 1,  10,   7, 3, 4'b0101, POOL_ON ? 18 : 0};

    if0.insValid = 1'b0; if0.insOpcode = OP_CFG; if0.insSel = 3'd0; if0.insData = '0;
    if0.addrReady = 1'b1;
    #22;
    check_eq("reset_vals0", 64'({if0.addrValid, if0.nReadAddress, if0.nWriteAddress, if0.bankSel, if0.writeEn,
                                 if0.busy, if0.done, if0.insReady}), 64'(1'b1));
    check_eq("reset_vals1", 64'({if1.addrValid, if1.bankSel, if1.busy, if1.done, if1.insReady}), 64'(1'b1));
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cfg(3'd0, tbl[i].rows);
      cfg(3'd1, tbl[i].cols);
      cfg(3'd2, tbl[i].ns);
      cfg(3'd3, tbl[i].ps);
      cfg(3'd4, tbl[i].p);
      run(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset dropped while the 3rd pair is on the bus
    cfg(3'd0, 2); cfg(3'd1, 3); cfg(3'd2, 8); cfg(3'd3, 4);
    send_cmd(OP_CONV, 3'd0, 0);
    nv = 0;
    for (int k = 0; k < 20 && nv < 3; k++) begin
      @(negedge CLK);
      if (if0.addrValid) nv++;
    end
    check_eq("rst_mid_third_pair", 64'({nv, if0.nReadAddress}), 64'({32'd3, 11'd2}));
    #2 RST_N = 1'b0;
    #1;
    check_eq("rst_async0", 64'({if0.addrValid, if0.nReadAddress, if0.nWriteAddress, if0.bankSel, if0.writeEn,
                                if0.busy, if0.done, if0.insReady}), 64'(1'b1));
    check_eq("rst_async1", 64'({if1.addrValid, if1.bankSel, if1.busy, if1.done, if1.insReady}), 64'(1'b1));
    @(posedge CLK); #1;
    check_eq("rst_no_pair", 64'({if0.addrValid, if1.addrValid}), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_release_ready", 64'({if0.insReady, if0.busy}), 64'(2'b10));
    // Config registers reset to zero rows/cols, so the next RUN is degenerate
    v = '{OP_CONV, 0, 0, 0, 0, 1, 4'b1111, 0};
    run(v, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
